// File: rtl/s1neuron_loader_pkg.sv
// Shared definitions for the first-layer neuron input loader and s1neuron:
// word/vector geometry, fixed-point split and the loader FSM state type.
package s1neuron_loader_pkg;

    localparam int INT_BITS  = 12;
    localparam int FRAC_BITS = 20;
    localparam int N         = INT_BITS + FRAC_BITS;  // bits per fixed-point word
    localparam int M         = 8;                     // words per vector

    // Counter width for an m-slot bank; never narrower than one bit.
    function automatic int cnt_width(input int m);
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

    localparam int CW = cnt_width(M);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/s1neuron_loader_if.sv
// Stream-in / vector-out bundle of the loader. The master side is the
// upstream word source plus the vector consumer; the slave side is the loader.
interface s1neuron_loader_if;

    logic                                                     in_valid;
    logic                                                     in_ready;
    logic [s1neuron_loader_pkg::N-1:0]                        in_x;
    logic [s1neuron_loader_pkg::N-1:0]                        in_w;
    logic                                                     in_last;
    logic                                                     out_valid;
    logic                                                     out_ready;
    logic [s1neuron_loader_pkg::M*s1neuron_loader_pkg::N-1:0] X;
    logic [s1neuron_loader_pkg::M*s1neuron_loader_pkg::N-1:0] W;
    logic                                                     frame_err;

    modport master (
        output in_valid, in_x, in_w, in_last, out_ready,
        input  in_ready, out_valid, X, W, frame_err
    );

    modport slave (
        input  in_valid, in_x, in_w, in_last, out_ready,
        output in_ready, out_valid, X, W, frame_err
    );

endinterface

// File: rtl/s1neuron_loader.sv
// Serial-to-parallel loader: collects up to M (x, w) words into two M-slot
// register banks, zero-fills short frames and holds the finished vector
// until the consumer takes it. The handoff cycle may also load slot 0.
module s1neuron_loader
    import s1neuron_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    s1neuron_loader_if.slave bus
);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            frame_err_q, frame_err_d;
    logic            in_ready;
    logic            out_valid;
    logic            accept;
    logic            handoff;
    logic            last_slot;
    logic            complete;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM outputs: ready is a pass-through of out_ready while a vector is held
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        if (state_q == HOLD) begin
            in_ready  = bus.out_ready;
            out_valid = 1'b1;
        end
    end

    assign accept    = bus.in_valid && in_ready;
    assign handoff   = out_valid && bus.out_ready;
    assign last_slot = (cnt_q == CW'(M - 1));
    // cnt is 0 in HOLD, so this also covers a one-word vector loaded on handoff
    assign complete  = accept && (bus.in_last || last_slot);

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (complete) state_d = HOLD;
            HOLD:    if (handoff)  state_d = complete ? HOLD : FILL;
            default: state_d = FILL;
        endcase
    end

    // Slot counter and frame-length error
    always_comb begin
        cnt_d       = cnt_q;
        frame_err_d = 1'b0;
        if (accept) begin
            cnt_d       = complete ? '0 : cnt_q + CW'(1);
            frame_err_d = last_slot && !bus.in_last;
        end
    end

    // Counter and error pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_slot
            logic         wr_en;
            logic         clr_en;
            logic [N-1:0] x_q, x_d;
            logic [N-1:0] w_q, w_d;

            // A new word wins over clearing, so handoff+accept leaves it in slot 0
            assign wr_en  = accept && (cnt_q == CW'(gi));
            assign clr_en = handoff || (complete && (CW'(gi) > cnt_q));

            // Slot next value: write, clear, or hold
            always_comb begin
                x_d = x_q;
                w_d = w_q;
                if (wr_en) begin
                    x_d = bus.in_x;
                    w_d = bus.in_w;
                end else if (clr_en) begin
                    x_d = '0;
                    w_d = '0;
                end
            end

            // Slot registers
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    x_q <= '0;
                    w_q <= '0;
                end else begin
                    x_q <= x_d;
                    w_q <= w_d;
                end
            end

            assign bus.X[N*(gi+1)-1 -: N] = x_q;
            assign bus.W[N*(gi+1)-1 -: N] = w_q;
        end
    endgenerate

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.frame_err = frame_err_q;

endmodule

// File: doc/s1neuron_loader.md
# s1neuron_loader

Serial-to-parallel input stage for the first-layer neuron. Accepts one fixed-point (x, w) pair per beat over a valid/ready stream and assembles M pairs into the flat `X`/`W` vectors consumed by `s1neuron`. A completed vector is held stable with `out_valid` until the consumer takes it. Short frames are zero-filled, so unused taps contribute nothing to the neuron sum.

## Interface
- `M`, 8: words per vector; equals the neuron's input count.
- `n`, 32: bits per fixed-point word (Q12.20 in the default configuration; the loader does not interpret the value).
- `clk`  in  1  : single clock, rising edge.
- `rst`  in  1  : asynchronous, active-high reset.
- `in_valid`  in  1  : the upstream beat is valid.
- `in_ready`  out  1  : the loader accepts the beat this cycle.
- `in_x`  in  n  : input activation word.
- `in_w`  in  n  : weight word.
- `in_last`  in  1  : the beat is the final word of the current vector.
- `out_valid`  out  1  : `X`/`W` hold a complete vector.
- `out_ready`  in  1  : the consumer takes the vector this cycle.
- `X`  out  M*n  : slot k occupies `X[n*(k+1)-1 -: n]`, with k = 0 as the first accepted word.
- `W`  out  M*n  : same slot layout as `X`.
- `frame_err`  out  1  : one-cycle pulse when the M-th word is accepted with `in_last`=0.

## Operation
- The state machine has two states, FILL and HOLD. FILL is the reset state.
- **Accept:** a beat is accepted when `in_valid && in_ready`.
- **FILL:**
  - `in_ready`=1 and `out_valid`=0.
  - An accept writes `in_x`/`in_w` into slot `cnt`, then `cnt` increments.
  - On an accept with `in_last`=1, or with `cnt`==M-1:
    - all slots above `cnt` are cleared to zero;
    - `cnt` returns to 0;
    - the next state is HOLD.
- **HOLD:**
  - `out_valid`=1. `in_ready`=`out_ready`, which is a combinational path.
  - On `out_valid && out_ready` (handoff), all slots are cleared.
    - If an accept occurs in the same cycle, slot 0 takes the new word and `cnt` becomes 1.
    - If that accepted word also has `in_last`=1, the state stays in HOLD with a one-word vector.
    - Otherwise the next state is FILL.
  - With no handoff, `X`/`W` and `out_valid` hold unchanged.
- **Frame length:**
  - A vector always completes at M words, whatever `in_last` is.
  - If the M-th word has `in_last`=0, `frame_err` pulses in the following cycle. Subsequent beats begin a new vector.
  - `in_last` on beat j < M-1 produces j+1 valid slots and zeros in the rest.
- **Data:** values are copied bit-exact. There is no arithmetic and no sign handling. A zero word is the neutral element for the downstream multiply/add.

## Timing
- **Reset** (asynchronous, takes effect immediately):
  - state=FILL, `cnt`=0;
  - `X`=`W`=0;
  - `out_valid`=0, `in_ready`=1, `frame_err`=0.
- **Latency:** `out_valid` rises on the clock edge that accepts the final word. It is visible the cycle after that beat is presented.
- **Throughput:** with `out_ready` held at 1 and `in_valid` held at 1, the loader completes one M-word vector every M cycles with no bubbles. The handoff cycle also accepts slot 0 of the next vector.
- **Stability:** while `out_valid`=1 and `out_ready`=0, `X`/`W` must not change.
- **Mid-operation reset:** a partially filled or held vector is discarded. No `frame_err` is produced.
- `frame_err` is registered and high for exactly one cycle.

## Structure
- The shared package holds:
  - the state enum {FILL, HOLD};
  - the counter-width function `$clog2(M)`, with a minimum of 1 bit;
  - the `M`, `n`, intbits and fracbits defaults shared with `s1neuron`.
- There is no sub-module. The block is one counter, one FSM and two M-slot register banks with per-slot write enables and clear logic.
- Instantiated directly in front of `s1neuron`: `X`→`X`, `W`→`W`. `out_ready` comes from the register stage that captures the neuron output `H`.

## Test plan
All scenarios use M=8 and n=32.
1. **Full frame:** 8 beats `in_x`=k+1, `in_w`=0x00100000, `in_last` on beat 7, `out_ready`=0 → `out_valid`=1 one cycle after beat 7; slot k of `X` = k+1; all slots of `W` = 0x00100000; `in_ready`=0 while held.
2. **Short frame:** 3 beats (x=0xAAAA0000, 0x1, 0x2), `in_last` on beat 2 → slots 0..2 are set and slots 3..7 = 0; `frame_err`=0.
3. **Back-to-back:** two 8-word frames, `in_valid`=`out_ready`=1 throughout → 16 consecutive accepts; second vector ready exactly 8 cycles after the first; no bubble, no stale data in any slot.
4. **Missing `in_last`:** 9 beats with `in_last`=0 on all → vector completes at word 8; `frame_err` pulses once; word 9 lands in slot 0 of the next vector.
5. **Backpressure:** vector held with `out_ready`=0 for 20 cycles while `in_valid`=1 → `X`/`W` unchanged and no accepts; raising `out_ready` hands off and accepts one beat in the same cycle.
6. **Reset mid-fill:** assert `rst` after 4 beats → `X`=`W`=0 and `out_valid`=0 immediately; `cnt` restarts so the next beat lands in slot 0.
